// File: rtl/alarm_controller.sv
`default_nettype none
// ============================================================================
// Module   : alarm_controller
// Brief    : Alarm time register, match edge detector and ring/snooze sequencer.
// Revision : 1.0
// ============================================================================
module alarm_controller #(
  parameter int SNOOZE_SEC       = 300,
  parameter int RING_TIMEOUT_SEC = 60,
  parameter int MAX_SNOOZE       = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sec_tick,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_sec,
  input  logic       alarm_en,
  input  logic       set_mode,
  input  logic       btn_min,
  input  logic       btn_sec,
  input  logic       snooze,
  input  logic       dismiss,
  output logic       play_sound,
  output logic [5:0] alarm_min,
  output logic [5:0] alarm_sec,
  output logic [1:0] state,
  output logic [3:0] snooze_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RINGING = 2'd2,
    SNOOZE  = 2'd3
  } state_t;

  localparam logic [15:0] c_ring_last   = 16'(RING_TIMEOUT_SEC - 1);
  localparam logic [15:0] c_snooze_last = 16'(SNOOZE_SEC - 1);
  localparam logic [3:0]  c_max_snooze  = 4'(MAX_SNOOZE);

  state_t      r_state;
  logic [15:0] r_timer;
  logic        r_match_d;
  logic [5:0]  r_alarm_min;
  logic [5:0]  r_alarm_sec;
  logic [3:0]  r_snooze_cnt;

  logic        w_match;
  logic        w_trigger;
  logic [5:0]  w_min_next;
  logic [5:0]  w_sec_next;

  // Matching is masked in edit mode so leaving edit on a match fires an edge.
  assign w_match    = (cur_min == r_alarm_min) & (cur_sec == r_alarm_sec) & ~set_mode;
  assign w_trigger  = w_match & ~r_match_d;
  assign w_min_next = (r_alarm_min == 6'd59) ? 6'd0 : r_alarm_min + 6'd1;
  assign w_sec_next = (r_alarm_sec == 6'd59) ? 6'd0 : r_alarm_sec + 6'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_timer      <= 16'd0;
      r_match_d    <= 1'b1;
      r_alarm_min  <= 6'd0;
      r_alarm_sec  <= 6'd0;
      r_snooze_cnt <= 4'd0;
    end else begin
      r_match_d <= w_match;
      if (set_mode && btn_min) r_alarm_min <= w_min_next;
      if (set_mode && btn_sec) r_alarm_sec <= w_sec_next;

      case (r_state)
        IDLE: begin
          if (alarm_en) r_state <= ARMED;
        end
        ARMED: begin
          if (!alarm_en) begin
            r_state      <= IDLE;
            r_timer      <= 16'd0;
            r_snooze_cnt <= 4'd0;
          end else if (w_trigger) begin
            r_state      <= RINGING;
            r_timer      <= 16'd0;
            r_snooze_cnt <= 4'd0;
          end
        end
        RINGING: begin
          if (!alarm_en) begin
            r_state      <= IDLE;
            r_timer      <= 16'd0;
            r_snooze_cnt <= 4'd0;
          end else if (dismiss) begin
            r_state      <= ARMED;
            r_snooze_cnt <= 4'd0;
          end else if (snooze && (r_snooze_cnt < c_max_snooze)) begin
            r_state      <= SNOOZE;
            r_snooze_cnt <= r_snooze_cnt + 4'd1;
            r_timer      <= 16'd0;
          end else if (sec_tick) begin
            if (r_timer == c_ring_last) begin
              r_state      <= ARMED;
              r_snooze_cnt <= 4'd0;
            end else begin
              r_timer <= r_timer + 16'd1;
            end
          end
        end
        SNOOZE: begin
          if (!alarm_en) begin
            r_state      <= IDLE;
            r_timer      <= 16'd0;
            r_snooze_cnt <= 4'd0;
          end else if (dismiss) begin
            r_state      <= ARMED;
            r_snooze_cnt <= 4'd0;
          end else if (sec_tick) begin
            if (r_timer == c_snooze_last) begin
              r_state <= RINGING;
              r_timer <= 16'd0;
            end else begin
              r_timer <= r_timer + 16'd1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Decoded straight from the state register so reset silences it at once.
  assign play_sound = (r_state == RINGING);
  assign state      = r_state;
  assign alarm_min  = r_alarm_min;
  assign alarm_sec  = r_alarm_sec;
  assign snooze_cnt = r_snooze_cnt;

endmodule
`default_nettype wire
